// File: rtl/video_pixel_gen_if.sv
// Raster output bundle from the pixel generator to the display PHY/encoder.
// The master drives strobes and pixel data; the slave observes them.
interface video_pixel_gen_if;
  logic        pclk;
  logic        eoh;
  logic        eov;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        daten;
  logic [23:0] pdata;

  modport master (
    output pclk, eoh, eov,
    output hsync, vsync,
    output blank, daten,
    output pdata
  );

  modport slave (
    input pclk, eoh, eov,
    input hsync, vsync,
    input blank, daten,
    input pdata
  );
endinterface

// File: rtl/video_pixel_gen.sv
// Programmable raster timing generator with an XY test-pattern source.
// One pixel per clk; outputs are registered one cycle behind the counters.
module video_pixel_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_ven,
  input  logic        ctrl_hsync_pol,
  input  logic        ctrl_vsync_pol,
  input  logic        ctrl_blank_pol,
  input  logic        ctrl_daten_pol,
  input  logic [7:0]  Thsync,
  input  logic [7:0]  Thgdel,
  input  logic [15:0] Thgate,
  input  logic [15:0] Thlen,
  input  logic [7:0]  Tvsync,
  input  logic [7:0]  Tvgdel,
  input  logic [15:0] Tvgate,
  input  logic [15:0] Tvlen,
  video_pixel_gen_if.master vid
);

  logic [15:0] hcnt;
  logic [15:0] vcnt;
  logic [15:0] hlast;
  logic [15:0] vlast;
  logic [16:0] hstart;
  logic [16:0] hstop;
  logic [16:0] vstart;
  logic [16:0] vstop;
  logic [7:0]  px;
  logic [7:0]  py;
  logic        hs_i;
  logic        vs_i;
  logic        hact;
  logic        vact;
  logic        act;
  logic        eoh_i;
  logic        eov_i;
  logic        idle;

  logic        hsync_q;
  logic        vsync_q;
  logic        blank_q;
  logic        daten_q;
  logic        eoh_q;
  logic        eov_q;
  logic [23:0] pdata_q;

  // A zero length is treated as one so the wrap point never underflows.
  assign hlast = (Thlen == 16'd0) ? 16'd0 : Thlen - 16'd1;
  assign vlast = (Tvlen == 16'd0) ? 16'd0 : Tvlen - 16'd1;

  assign hstart = {9'd0, Thsync} + {9'd0, Thgdel};
  assign hstop  = hstart + {1'b0, Thgate};
  assign vstart = {9'd0, Tvsync} + {9'd0, Tvgdel};
  assign vstop  = vstart + {1'b0, Tvgate};

  assign hs_i  = hcnt < {8'd0, Thsync};
  assign vs_i  = vcnt < {8'd0, Tvsync};
  assign hact  = ({1'b0, hcnt} >= hstart) &&
                 ({1'b0, hcnt} < hstop);
  assign vact  = ({1'b0, vcnt} >= vstart) &&
                 ({1'b0, vcnt} < vstop);
  assign act   = hact & vact;
  assign eoh_i = hcnt >= hlast;
  assign eov_i = eoh_i & (vcnt >= vlast);

  // Offsets only need their low byte, so subtract in 8 bits.
  assign px = hcnt[7:0] - hstart[7:0];
  assign py = vcnt[7:0] - vstart[7:0];

  assign idle = rst_n | ~ctrl_ven;

  always_ff @(posedge clk) begin
    if (idle) begin
      hcnt <= 16'd0;
      vcnt <= 16'd0;
    end else if (eoh_i) begin
      hcnt <= 16'd0;
      vcnt <= eov_i ? 16'd0 : vcnt + 16'd1;
    end else begin
      hcnt <= hcnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (idle) begin
      hsync_q <= ctrl_hsync_pol;
      vsync_q <= ctrl_vsync_pol;
      blank_q <= ~ctrl_blank_pol;
      daten_q <= ctrl_daten_pol;
      eoh_q   <= 1'b0;
      eov_q   <= 1'b0;
      pdata_q <= 24'd0;
    end else begin
      hsync_q <= hs_i ^ ctrl_hsync_pol;
      vsync_q <= vs_i ^ ctrl_vsync_pol;
      blank_q <= ~act ^ ctrl_blank_pol;
      daten_q <= act ^ ctrl_daten_pol;
      eoh_q   <= eoh_i;
      eov_q   <= eov_i;
      pdata_q <= act ? {px, py, px ^ py} : 24'd0;
    end
  end

  assign vid.pclk  = ~clk;
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
  assign vid.blank = blank_q;
  assign vid.daten = daten_q;
  assign vid.eoh   = eoh_q;
  assign vid.eov   = eov_q;
  assign vid.pdata = pdata_q;

endmodule

// File: tb/tb_video_pixel_gen.sv
// Directed bench for video_pixel_gen: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_video_pixel_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_ven;
  logic        hp, vp, bp, dp;
  logic [7:0]  Thsync, Thgdel, Tvsync, Tvgdel;
  logic [15:0] Thgate, Thlen, Tvgate, Tvlen;

  always #5 clk = ~clk;

  video_pixel_gen_if vif ();

  video_pixel_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_ven       (ctrl_ven),
    .ctrl_hsync_pol (hp),
    .ctrl_vsync_pol (vp),
    .ctrl_blank_pol (bp),
    .ctrl_daten_pol (dp),
    .Thsync         (Thsync),
    .Thgdel         (Thgdel),
    .Thgate         (Thgate),
    .Thlen          (Thlen),
    .Tvsync         (Tvsync),
    .Tvgdel         (Tvgdel),
    .Tvgate         (Tvgate),
    .Tvlen          (Tvlen),
    .vid            (vif)
  );

  typedef enum logic [1:0] {K_VEC, K_CNT, K_CLR} kind_t;
  typedef struct {
    kind_t       kind;
    string       name;
    logic [30:0] exp;
    logic [30:0] mask;
    int          cnt;
  } exp_t;

  // {pclk, hsync, vsync, blank, daten, eoh, eov, pdata}
  localparam logic [30:0] M_ALL = 31'h7FFF_FFFF;
  localparam logic [30:0] M_HS  = 31'h6000_0000;
  localparam logic [30:0] M_HV  = 31'h7000_0000;
  localparam logic [30:0] M_EOH = 31'h4200_0000;
  localparam logic [30:0] M_EV  = 31'h4300_0000;
  localparam logic [30:0] M_HVE = 31'h7200_0000;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [30:0] mon_act;
  int          checks = 0;
  int          errors = 0;
  int          dcount = 0;

  function automatic logic [30:0] pv(
    input logic hs, input logic vs,
    input logic bl, input logic de,
    input logic eh, input logic ev,
    input logic [23:0] pd);
    return {1'b1, hs, vs, bl, de, eh, ev, pd};
  endfunction

  task automatic push_vec(input string nm,
                          input logic [30:0] e,
                          input logic [30:0] m);
    exp_t x;
    x.kind = K_VEC; x.name = nm;
    x.exp = e; x.mask = m; x.cnt = 0;
    sb.push_back(x);
  endtask

  task automatic push_cnt(input string nm, input int c);
    exp_t x;
    x.kind = K_CNT; x.name = nm;
    x.exp = '0; x.mask = '0; x.cnt = c;
    sb.push_back(x);
  endtask

  task automatic push_clr();
    exp_t x;
    x.kind = K_CLR; x.name = "clr";
    x.exp = '0; x.mask = '0; x.cnt = 0;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    mon_act = {vif.pclk, vif.hsync, vif.vsync,
               vif.blank, vif.daten, vif.eoh,
               vif.eov, vif.pdata};
    if (vif.daten) dcount++;
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_VEC: begin
          checks++;
          if ((mon_act & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
            errors++;
            $display("FAIL %s got %h want %h", mon_e.name,
                     mon_act & mon_e.mask, mon_e.exp & mon_e.mask);
          end
        end
        K_CNT: begin
          checks++;
          if (dcount != mon_e.cnt) begin
            errors++;
            $display("FAIL %s got %0d want %0d", mon_e.name,
                     dcount, mon_e.cnt);
          end
          dcount = 0;
        end
        default: dcount = 0;
      endcase
    end
  end

  initial begin
    rst_n = 1'b1; ctrl_ven = 1'b1;
    hp = 1'b0; vp = 1'b0; bp = 1'b0; dp = 1'b0;
    Thsync = 8'd8;  Thgdel = 8'd12;
    Thgate = 16'd100; Thlen = 16'd130;
    Tvsync = 8'd1;  Tvgdel = 8'd2;
    Tvgate = 16'd16; Tvlen = 16'd22;

    tick();
    tick();
    push_vec("reset", pv(0,0,1,0,0,0,24'h0), M_ALL);
    tick();
    push_vec("reset2", pv(0,0,1,0,0,0,24'h0), M_ALL);
    push_clr();
    rst_n = 1'b0;

    // Frame 1 defaults, then polarity inverted in frame 2.
    for (int n = 0; n <= 3638; n++) begin
      tick();
      case (n)
        0:    push_vec("px00", pv(1,1,1,0,0,0,24'h0), M_ALL);
        7:    push_vec("hs7", pv(1,0,0,0,0,0,24'h0), M_HS);
        8:    push_vec("hs8", pv(0,1,0,0,0,0,24'h0), M_HV);
        128:  push_vec("eoh128", pv(0,0,0,0,0,0,24'h0), M_EOH);
        129:  push_vec("eoh129", pv(0,0,0,0,1,0,24'h0), M_EV);
        130:  push_vec("line1", pv(1,0,0,0,0,0,24'h0), M_HVE);
        409:  push_vec("px19_3", pv(0,0,1,0,0,0,24'h0), M_ALL);
        410:  push_vec("px20_3", pv(0,0,0,1,0,0,24'h0), M_ALL);
        545:  push_vec("px25_4", pv(0,0,0,1,0,0,24'h050104), M_ALL);
        2459: push_vec("px119_18", pv(0,0,0,1,0,0,24'h630F6C), M_ALL);
        2460: push_vec("px120_18", pv(0,0,1,0,0,0,24'h0), M_ALL);
        2490: push_vec("px20_19", pv(0,0,1,0,0,0,24'h0), M_ALL);
        2729: push_vec("eoh_l20", pv(0,0,0,0,1,0,24'h0), M_EV);
        2859: begin
          push_vec("eov", pv(0,0,0,0,1,1,24'h0), M_EV);
          push_cnt("de_count", 1600);
        end
        2860: begin
          push_vec("f2_px00", pv(1,1,1,0,0,0,24'h0), M_ALL);
          hp = 1'b1; vp = 1'b1; bp = 1'b1; dp = 1'b1;
        end
        2865: push_vec("pol_5_0", pv(0,0,0,1,0,0,24'h0), M_ALL);
        2870: push_vec("pol_10_0", pv(1,0,0,1,0,0,24'h0), M_ALL);
        2989: push_vec("pol_eoh", pv(0,0,0,0,1,0,24'h0), M_EV);
        3405: push_vec("pol_25_4", pv(1,1,1,0,0,0,24'h050104), M_ALL);
        3540: push_vec("pol_30_5", pv(1,1,1,0,0,0,24'h0A0208), M_ALL);
        3550: begin
          hp = 1'b0; vp = 1'b0; bp = 1'b0; dp = 1'b0;
        end
        3638: ctrl_ven = 1'b0;
        default: ;
      endcase
    end

    for (int i = 0; i < 3; i++) begin
      tick();
      push_vec("idle", pv(0,0,1,0,0,0,24'h0), M_ALL);
    end
    ctrl_ven = 1'b1;

    for (int r = 0; r <= 1349; r++) begin
      tick();
      case (r)
        0:    push_vec("ren_px00", pv(1,1,1,0,0,0,24'h0), M_ALL);
        7:    push_vec("ren_hs7", pv(1,0,0,0,0,0,24'h0), M_HS);
        8:    push_vec("ren_hs8", pv(0,0,0,0,0,0,24'h0), M_HS);
        1349: begin
          push_vec("px49_10", pv(0,0,0,1,0,0,24'h1D071A), M_ALL);
          rst_n = 1'b1;
        end
        default: ;
      endcase
    end

    tick();
    push_vec("mid_rst", pv(0,0,1,0,0,0,24'h0), M_ALL);
    tick();
    push_vec("mid_rst2", pv(0,0,1,0,0,0,24'h0), M_ALL);
    push_clr();
    rst_n = 1'b0;

    for (int q = 0; q <= 3000; q++) begin
      tick();
      case (q)
        0:    push_vec("rst_px00", pv(1,1,1,0,0,0,24'h0), M_ALL);
        2729: push_vec("rst_eoh", pv(0,0,0,0,1,0,24'h0), M_EV);
        2859: begin
          push_vec("rst_eov", pv(0,0,0,0,1,1,24'h0), M_EV);
          push_cnt("rst_de_count", 1600);
        end
        2860: push_vec("rst_f2", pv(0,0,0,0,0,0,24'h0), M_EV);
        2919: begin
          push_vec("shr_pre", pv(0,0,0,0,0,0,24'h0), M_EOH);
          Thlen = 16'd40;
        end
        2920: push_vec("shr_wrap", pv(0,0,0,0,1,0,24'h0), M_EOH);
        2921: push_vec("shr_l1", pv(1,0,0,0,0,0,24'h0), M_HVE);
        2959: push_vec("shr_39", pv(0,0,0,0,0,0,24'h0), M_EOH);
        2960: push_vec("shr_40", pv(0,0,0,0,1,0,24'h0), M_EOH);
        2999: push_vec("shr_79", pv(0,0,0,0,0,0,24'h0), M_EOH);
        3000: push_vec("shr_80", pv(0,0,0,0,1,0,24'h0), M_EOH);
        default: ;
      endcase
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_pixel_gen.md
# video_pixel_gen

Programmable raster timing generator with a built-in test-pattern source. It produces hsync/vsync/blank/data-enable strobes and 24-bit pixel data from runtime horizontal and vertical timing registers. It sits between the register/control block and the display interface (PHY or encoder). It runs at one pixel per `clk` cycle.

## Interface
- No parameters.
- `clk` in 1: system clock; one pixel per rising edge.
- `rst_n` in 1: reset, synchronous, active-high. `rst_n`=1 resets the block (the name is historical).
- `ctrl_ven` in 1: video enable.
- `ctrl_hsync_pol`, `ctrl_vsync_pol`, `ctrl_blank_pol`, `ctrl_daten_pol` in 1 each: output polarity. 0 gives an active-high output; 1 inverts it.
- `Thsync` in 8: hsync width, in pixels.
- `Thgdel` in 8: horizontal back porch, in pixels.
- `Thgate` in 16: visible pixels per line.
- `Thlen` in 16: total pixels per line.
- `Tvsync` in 8: vsync width, in lines.
- `Tvgdel` in 8: vertical back porch, in lines.
- `Tvgate` in 16: visible lines per frame.
- `Tvlen` in 16: total lines per frame.
- `eoh` out 1: end-of-line pulse.
- `eov` out 1: end-of-frame pulse.
- `pclk` out 1: pixel clock, equal to ~`clk`.
- `hsync`, `vsync`, `blank`, `daten` out 1 each: raster strobes, polarity applied.
- `pdata` out 24: pixel data {R[7:0],G[7:0],B[7:0]}.

## Operation
- **Counters:**
  - `hcnt` (16b) counts 0..Thlen-1; `vcnt` (16b) counts 0..Tvlen-1.
  - `hcnt` increments each enabled cycle.
  - When `hcnt` >= Thlen-1, `hcnt` wraps to 0 and `vcnt` advances.
  - When `vcnt` >= Tvlen-1 at a line wrap, `vcnt` wraps to 0.
  - The >= compare guarantees recovery if a length register is reduced mid-frame. A length of 0 behaves as 1.
- **Internal active-high terms:**
  - hs_i = `hcnt` < Thsync.
  - vs_i = `vcnt` < Tvsync.
  - hact = Thsync+Thgdel <= `hcnt` < Thsync+Thgdel+Thgate. Sums are computed in 17 bits, so there is no overflow.
  - vact = Tvsync+Tvgdel <= `vcnt` < Tvsync+Tvgdel+Tvgate.
  - act = hact & vact.
  - eoh_i = (`hcnt` >= Thlen-1).
  - eov_i = eoh_i & (`vcnt` >= Tvlen-1).
- **Outputs (registered):**
  - `hsync` = hs_i ^ `ctrl_hsync_pol`.
  - `vsync` = vs_i ^ `ctrl_vsync_pol`.
  - `blank` = ~act ^ `ctrl_blank_pol`.
  - `daten` = act ^ `ctrl_daten_pol`.
  - `eoh` and `eov` are always active-high, one cycle wide.
- **Test pattern:**
  - x = `hcnt` - (Thsync+Thgdel) and y = `vcnt` - (Tvsync+Tvgdel), both truncated to 8 bits.
  - When act=1, `pdata` = {x, y, x^y}; otherwise `pdata` = 0.
- **`ctrl_ven`=0:**
  - Counters are held at (0,0).
  - Outputs are forced to the idle state: strobes deasserted (hs_i=vs_i=act=0, so `blank` is asserted, with polarity applied), `eoh`=`eov`=0, `pdata`=0.
  - Re-enabling restarts the frame at pixel (0,0).
- Polarity and timing inputs are sampled every cycle. Changes take effect on the next registered output; the bench must not depend on the output during the change cycle.

## Timing
- **Reset (`rst_n`=1):**
  - Counters are 0.
  - `hsync`=`ctrl_hsync_pol`, `vsync`=`ctrl_vsync_pol`.
  - `blank`=~`ctrl_blank_pol` (asserted), `daten`=`ctrl_daten_pol` (deasserted).
  - `eoh`=`eov`=0, `pdata`=0.
  - Reset has priority over `ctrl_ven`. Reset mid-frame returns the block to (0,0) on the next edge.
- **Latency:**
  - On the first edge with `rst_n`=0 and `ctrl_ven`=1, the outputs take the values for pixel (0,0) and the counters move to (1,0).
  - Outputs are therefore 1 cycle behind the counters and are mutually aligned.
- **Periods:**
  - A line is Thlen cycles; a frame is Thlen×Tvlen cycles.
  - `eoh` is high on the last pixel of each line.
  - `eov` is high coincident with the `eoh` of the last line.
- `pclk` is the inverted `clk`: outputs change on `clk` rise and are sampled on `pclk` rise.
- Consistent programming requires Thsync+Thgdel+Thgate <= Thlen (and the vertical equivalent). When this is violated, the active region is simply clipped by the wrap.

## Test plan
- **Defaults:** Thsync=8, Thgdel=12, Thgate=100, Thlen=130; Tvsync=1, Tvgdel=2, Tvgate=16, Tvlen=22; all pol=0, ven=1; release reset.
  - `hsync`=1 for output cycles 0-7 of each line.
  - `eoh` every 130 cycles.
  - `eov` every 2860 cycles.
  - `vsync`=1 during line 0 only.
- **Active window (defaults):**
  - `daten`=1 for pixels 20..119 of lines 3..18, which is 1600 cycles/frame.
  - `blank`=~`daten`.
  - `pdata` at (20,3) = 0x000000.
  - `pdata` at (25,4) = 0x050104.
  - `pdata`=0 outside the window.
- **Polarity:** set all four pol=1.
  - `hsync` is low for 8 cycles per line.
  - `vsync` is low on line 0.
  - `blank` is high inside the window.
  - `daten` is low inside the window.
  - `eoh` and `eov` are unchanged.
- **Enable:** drop `ctrl_ven` mid-line.
  - Next cycle: idle levels, `pdata`=0, no `eoh`.
  - On re-enable, `hsync` asserts immediately for 8 cycles from pixel (0,0).
- **Reset mid-frame:** assert `rst_n`=1 at line 10 pixel 50.
  - Outputs go to reset values on the next edge.
  - After release, the frame restarts at (0,0) and `eov` follows 2860 cycles later.
- **Shrink:** reduce Thlen from 130 to 40 while `hcnt`=60.
  - Line wraps on the next cycle (>= compare).
  - Subsequent `eoh` period is 40 cycles.
